traffic_timer: RTL and testbench
================================

# traffic_timer

Interval timer and car-sensor conditioner that sits directly upstream of the traffic-light controller FSM. It restarts on the controller's start-timer pulse `st`. It returns the short-interval flag `ts` and long-interval flag `tl`, and a synchronized, debounced farm-road car-present flag `c`. It converts the raw clock into slow ticks, so the controller never counts cycles itself.

## Interface

- `PRESCALE`, 1000: clk cycles per timer tick; legal range ≥ 1.
- `SHORT_TICKS`, 5: ticks after restart until `ts` asserts; legal range ≥ 1.
- `LONG_TICKS`, 30: ticks after restart until `tl` asserts; must be > `SHORT_TICKS` and < 2^`CNT_W`.
- `CNT_W`, 8: tick-counter width.
- `DEB_CYCLES`, 4: consecutive stable cycles needed to flip `c`; legal range ≥ 1.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `st`  in  1  restart request from the controller, sampled on each rising edge.
- `car_raw`  in  1  raw car sensor, asynchronous to `clk`.
- `ts`  out  1  short interval elapsed since last restart.
- `tl`  out  1  long interval elapsed since last restart.
- `c`  out  1  conditioned car-present flag.
- `tick_cnt`  out  `CNT_W`  ticks since last restart (saturating); debug/observability.

## Operation

- Reset (`rst`=0) immediately clears, independent of `clk`:
  - the prescaler, `tick_cnt`, `ts`, `tl` and `c`;
  - both synchronizer flops and the debounce counter.
  - All outputs are 0 while `rst`=0.
- Prescaler:
  - counts 0..`PRESCALE`-1;
  - on the edge where it equals `PRESCALE`-1 it wraps to 0 and issues a one-cycle internal tick.
  - With `PRESCALE`=1, a tick occurs every cycle.
- Tick counter:
  - increments on each tick;
  - saturates at `LONG_TICKS`; once saturated, the prescaler holds at 0 and no further ticks occur.
- Restart:
  - `st`=1 at an edge clears the prescaler and `tick_cnt` to 0 and drives `ts`=`tl`=0.
  - Restart has priority over a coincident tick.
  - `st` held high keeps everything at 0.
- Flags are registered and updated on the same edge as `tick_cnt`:
  - `ts` = (next `tick_cnt` ≥ `SHORT_TICKS`);
  - `tl` = (next `tick_cnt` ≥ `LONG_TICKS`).
  - Both are monotonic between restarts. `tl`=1 implies `ts`=1.
- Car path:
  - `car_raw` passes through a 2-flop synchronizer, then the conditioning stage (see Configuration).
  - The car path is independent of `st`.

## Timing

- Define restart edge E0 as the edge sampling `st`=1 with `st`=0 afterwards.
  - `tick_cnt` = n after edge E0 + n·`PRESCALE`.
  - `ts` is high from edge E0 + `SHORT_TICKS`·`PRESCALE`.
  - `tl` is high from edge E0 + `LONG_TICKS`·`PRESCALE`.
- After reset release, counting starts as if the deasserting edge were E0.
- Restart while `ts`/`tl` are high: both are low in the cycle following the restart edge.
- Synchronizer latency: a `car_raw` change meeting setup before edge 1 appears at the synchronizer output after edge 2.
- Asynchronous reset mid-count or mid-debounce: outputs drop to 0 without waiting for an edge. Counting resumes from 0 on release.

## Configuration

- Macro `TRAFFIC_TIMER_DEBOUNCE_EN`.
- Defined:
  - The debounce counter increments each edge while the synchronized value ≠ `c`. It clears whenever they are equal.
  - When it reaches `DEB_CYCLES`, `c` flips and the counter clears.
  - A clean change flips `c` at edge 2 + `DEB_CYCLES`.
  - Pulses shorter than `DEB_CYCLES` cycles never reach `c`.
- Undefined:
  - `c` is the synchronized value registered once. A change appears after edge 3.
  - No debounce counter is instantiated; `DEB_CYCLES` is ignored.

## Test plan

Parameters: `PRESCALE`=4, `SHORT_TICKS`=2, `LONG_TICKS`=5, `CNT_W`=8, `DEB_CYCLES`=3.

1. Drive `rst`=0 between edges with `car_raw`=1 → `ts`=`tl`=`c`=0 and `tick_cnt`=0 immediately. Release reset → `ts` rises after edge 8 and `tl` after edge 20.
2. Pulse `st` at E0 → `tick_cnt` steps 1..5 at E0+4, +8, …, +20. `ts` rises at E0+8 and `tl` at E0+20. `tick_cnt` stays 5 for 50 further cycles.
3. Pulse `st` while `tl`=1 → `ts`=`tl`=0 next cycle. `ts` re-rises 8 edges later. An `st` pulse coincident with a prescaler wrap leaves `tick_cnt`=0.
4. Hold `st`=1 for 10 cycles → `tick_cnt`, `ts` and `tl` remain 0 throughout. `ts` rises 8 edges after the last `st`=1 edge.
5. With the debounce macro defined: a 2-cycle `car_raw` glitch leaves `c`=0. A steady `car_raw`=1 gives `c`=1 at edge 5, and `c`=0 at edge 5 after `car_raw` returns to 0. With the macro undefined, the same steady step gives `c`=1 at edge 3.
6. Assert `rst` at `tick_cnt`=3 with `c`=1 → all outputs 0 asynchronously. After release, `ts` rises 8 edges later.

Source files
------------

// File: rtl/traffic_timer.sv
// traffic_timer: prescaled restart timer (ts/tl flags) plus car-sensor sync/conditioner.
// Define TRAFFIC_TIMER_DEBOUNCE_EN to debounce c over DEB_CYCLES stable cycles.
module traffic_timer #(
    parameter int PRESCALE    = 1000,
    parameter int SHORT_TICKS = 5,
    parameter int LONG_TICKS  = 30,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic             car_raw,
    output logic             ts,
    output logic             tl,
    output logic             c,
    output logic [CNT_W-1:0] tick_cnt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] SHORT   = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] LONG    = CNT_W'(LONG_TICKS);

    if (PRESCALE < 1 || SHORT_TICKS < 1 || DEB_CYCLES < 1 ||
        LONG_TICKS <= SHORT_TICKS || LONG_TICKS >= (1 << CNT_W)) begin : g_bad_cfg
        $error("traffic_timer: illegal parameter combination");
    end

    logic [PW-1:0]    pre;
    logic             sat;
    logic             tick;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sync1;
    logic             sync2;

    assign sat  = (tick_cnt == LONG);
    assign tick = !sat && (pre == PRE_MAX);

    always_comb begin
        cnt_nxt = tick_cnt;
        if (st)
            cnt_nxt = '0;
        else if (tick)
            cnt_nxt = tick_cnt + 1'b1;
    end

    // Prescaler parks at 0 once saturated, so no ticks are issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre      <= '0;
            tick_cnt <= '0;
            ts       <= 1'b0;
            tl       <= 1'b0;
        end else begin
            if (st || sat || tick)
                pre <= '0;
            else
                pre <= pre + 1'b1;
            tick_cnt <= cnt_nxt;
            ts       <= (cnt_nxt >= SHORT);
            tl       <= (cnt_nxt >= LONG);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= car_raw;
            sync2 <= sync1;
        end
    end

`ifdef TRAFFIC_TIMER_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic [DW-1:0] deb;

    // Counts consecutive cycles the synced input disagrees with c.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            c   <= 1'b0;
        end else if (sync2 == c) begin
            deb <= '0;
        end else if (deb == DEB_LAST) begin
            deb <= '0;
            c   <= ~c;
        end else begin
            deb <= deb + 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            c <= 1'b0;
        else
            c <= sync2;
    end
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: randomized scoreboard bench for traffic_timer.
// Expected outputs come from an edge-count model and a car-sample history.
module tb_traffic_timer;

    localparam int P   = 4;
    localparam int SH  = 2;
    localparam int LG  = 5;
    localparam int W   = 8;
    localparam int DEB = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         st = 1'b0;
    logic         car_raw = 1'b0;
    logic         ts;
    logic         tl;
    logic         c;
    logic [W-1:0] tick_cnt;

    traffic_timer #(
        .PRESCALE   (P),
        .SHORT_TICKS(SH),
        .LONG_TICKS (LG),
        .CNT_W      (W),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .st      (st),
        .car_raw (car_raw),
        .ts      (ts),
        .tl      (tl),
        .c       (c),
        .tick_cnt(tick_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         ts;
        logic         tl;
        logic         c;
    } exp_t;

    localparam exp_t ZERO = '0;

    exp_t q[$];
    exp_t me;
    int   n_chk = 0;
    int   n_fail = 0;

    int   k;
    logic m_c;
    int   run;
    logic hist[$];
    logic car_cur = 1'b0;
    int   car_left = 0;

    task automatic model_clear();
        k    = 0;
        m_c  = 1'b0;
        run  = 0;
        hist = '{1'b0, 1'b0};
    endtask

    // One clock edge: k edges since restart; c follows the sample history.
    task automatic model_edge(input logic s, input logic x);
        logic sy;
        int   cnt;
        exp_t e;
        if (s)
            k = 0;
        else if (k < LG * P)
            k++;
        sy = hist[hist.size() - 2];
`ifdef TRAFFIC_TIMER_DEBOUNCE_EN
        if (sy != m_c) begin
            run++;
            if (run == DEB) begin
                m_c = ~m_c;
                run = 0;
            end
        end else begin
            run = 0;
        end
`else
        m_c = sy;
`endif
        hist.push_back(x);
        if (hist.size() > 4)
            void'(hist.pop_front());
        cnt = k / P;
        if (cnt > LG)
            cnt = LG;
        e.cnt = cnt[W-1:0];
        e.ts  = (cnt >= SH);
        e.tl  = (cnt >= LG);
        e.c   = m_c;
        q.push_back(e);
    endtask

    task automatic step(input logic s, input logic x);
        st      = s;
        car_raw = x;
        @(posedge clk);
        model_edge(s, x);
        @(negedge clk);
    endtask

    task automatic next_car(output logic x);
        if (car_left == 0) begin
            car_cur  = 1'($urandom_range(0, 1));
            car_left = $urandom_range(1, 8);
        end
        car_left--;
        x = car_cur;
    endtask

    task automatic rand_steps(input int n, input int st_mod);
        logic x;
        logic s;
        repeat (n) begin
            next_car(x);
            s = ($urandom_range(0, st_mod - 1) == 0);
            step(s, x);
        end
    endtask

    // Reset lands between a rising edge and the sampling falling edge.
    task automatic async_reset(input int hold);
        st = 1'b0;
        @(posedge clk);
        model_edge(1'b0, car_raw);
        #2;
        rst     = 1'b0;
        car_raw = 1'b1;
        void'(q.pop_back());
        q.push_back(ZERO);
        model_clear();
        repeat (hold) begin
            @(posedge clk);
            q.push_back(ZERO);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                me = q.pop_front();
                n_chk++;
                if (tick_cnt !== me.cnt || ts !== me.ts ||
                    tl !== me.tl || c !== me.c) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got cnt=%0d ts=%b tl=%b c=%b, expected cnt=%0d ts=%b tl=%b c=%b",
                             $time, tick_cnt, ts, tl, c, me.cnt, me.ts, me.tl, me.c);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_clear();
        rst     = 1'b0;
        car_raw = 1'b1;
        st      = 1'b0;
        repeat (3) begin
            @(posedge clk);
            q.push_back(ZERO);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;

        repeat (40) step(1'b0, 1'b1);
        rand_steps(150, 25);

        repeat (10) step(1'b1, 1'b0);
        repeat (60) step(1'b0, 1'b0);

        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1);
        repeat (8) step(1'b0, 1'b0);

        step(1'b1, 1'b1);
        repeat (11) step(1'b0, 1'b1);
        async_reset(2);
        repeat (40) step(1'b0, 1'b0);

        rand_steps(200, 30);
        rand_steps(37, 30);
        async_reset(1);
        rand_steps(100, 30);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
